down_counter_jk: RTL and testbench

//   Synchronous modulo-N down counter built from JK flip-flop stages.
//   It is the count-down counterpart of the lab's up counter: same clk/reset

---
 rtl/down_counter_jk.sv | 79 +++++++
 tb/tb_down_counter_jk.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter_jk.sv
// Modulo-MODULUS down counter built from JK flip-flop stages, with parallel load,
// count enable, a combinational terminal-count flag and a registered borrow pulse.
module down_counter_jk #(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             borrow_q;
    logic             borrow_d;

    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_zero;
    logic             force_set;

    always_comb begin
        at_zero   = (q_q == '0);
        // Reset, load and the 0 -> MODULUS-1 wrap all bypass the toggle chain.
        force_set = reset | load | (en & at_zero);
        target    = MAX_VAL;
        if (!reset && load && ({1'b0, load_val} < MOD_EXT)) begin
            target = load_val;
        end
        borrow_d  = ~reset & ~load & en & at_zero;

        toggle    = '0;
        toggle[0] = en;
        for (int i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] & ~q_q[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            assign j[gi] = force_set ?  target[gi] : toggle[gi];
            assign k[gi] = force_set ? ~target[gi] : toggle[gi];
        end
    endgenerate

    // Characteristic JK equation: Q+ = J&~Q | ~K&Q
    always_comb begin
        q_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            q_d[i] = (j[i] & ~q_q[i]) | (~k[i] & q_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q      <= MAX_VAL;
            borrow_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            borrow_q <= borrow_d;
        end
    end

    assign q      = q_q;
    assign tc     = at_zero & en;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_down_counter_jk.sv
// Checks two counter configurations (2-bit mod 4, 3-bit mod 5) with directed
// vectors plus a behavioural reference model compared on every cycle.
module tb_down_counter_jk;

    logic       clk;
    logic       rst_a, en_a, load_a;
    logic [1:0] lv_a;
    logic [1:0] q_a;
    logic       tc_a, borrow_a;
    logic       rst_b, en_b, load_b;
    logic [2:0] lv_b;
    logic [2:0] q_b;
    logic       tc_b, borrow_b;

    int checks;
    int errors;

    down_counter_jk #(.WIDTH(2), .MODULUS(4)) dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .load(load_a), .load_val(lv_a),
        .q(q_a), .tc(tc_a), .borrow(borrow_a)
    );

    down_counter_jk #(.WIDTH(3), .MODULUS(5)) dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .load(load_b), .load_val(lv_b),
        .q(q_b), .tc(tc_b), .borrow(borrow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference models, independent of the JK structure.
    logic [1:0] m_qa;
    logic       m_ba, m_va;
    logic [2:0] m_qb;
    logic       m_bb, m_vb;

    initial begin
        m_va = 1'b0;
        m_vb = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_a) begin
            m_qa <= 2'd3; m_ba <= 1'b0; m_va <= 1'b1;
        end else if (load_a) begin
            m_qa <= lv_a; m_ba <= 1'b0;
        end else if (en_a) begin
            m_qa <= (m_qa == 2'd0) ? 2'd3 : m_qa - 2'd1;
            m_ba <= (m_qa == 2'd0);
        end else begin
            m_ba <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_b) begin
            m_qb <= 3'd4; m_bb <= 1'b0; m_vb <= 1'b1;
        end else if (load_b) begin
            m_qb <= (lv_b < 3'd5) ? lv_b : 3'd4; m_bb <= 1'b0;
        end else if (en_b) begin
            m_qb <= (m_qb == 3'd0) ? 3'd4 : m_qb - 3'd1;
            m_bb <= (m_qb == 3'd0);
        end else begin
            m_bb <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_va) begin
            checks++;
            if (q_a !== m_qa || borrow_a !== m_ba || tc_a !== ((m_qa == 2'd0) && en_a)) begin
                errors++;
                $display("FAIL model_a t=%0t: q=%0d borrow=%b tc=%b, required q=%0d borrow=%b tc=%b",
                         $time, q_a, borrow_a, tc_a, m_qa, m_ba, (m_qa == 2'd0) && en_a);
            end
        end
        if (m_vb) begin
            checks++;
            if (q_b !== m_qb || borrow_b !== m_bb || tc_b !== ((m_qb == 3'd0) && en_b)) begin
                errors++;
                $display("FAIL model_b t=%0t: q=%0d borrow=%b tc=%b, required q=%0d borrow=%b tc=%b",
                         $time, q_b, borrow_b, tc_b, m_qb, m_bb, (m_qb == 3'd0) && en_b);
            end
        end
    end

    typedef struct {
        logic       rst;
        logic       ld;
        logic       en;
        logic [2:0] lv;
        logic [2:0] exp_q;
        logic       exp_borrow;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic ld, input logic en,
                                input logic [2:0] lv, input logic [2:0] eq, input logic eb);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = en; v.lv = lv; v.exp_q = eq; v.exp_borrow = eb;
        return v;
    endfunction

    localparam int NV = 23;
    vec_t vecs [NV];

    // Expected values for the 2-bit counter after each of 8 enabled edges.
    logic [1:0] seq_q [8];
    logic       seq_b [8];

    task automatic check_a(input string name, input logic [1:0] eq, input logic eb, input logic et);
        checks++;
        if (q_a !== eq || borrow_a !== eb || tc_a !== et) begin
            errors++;
            $display("FAIL %s: q=%0d borrow=%b tc=%b, required q=%0d borrow=%b tc=%b",
                     name, q_a, borrow_a, tc_a, eq, eb, et);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a = 1'b0; en_a = 1'b0; load_a = 1'b0; lv_a = 2'd0;
        rst_b = 1'b0; en_b = 1'b0; load_b = 1'b0; lv_b = 3'd0;

        vecs[0]  = mk(1, 0, 0, 3'd0, 3'd4, 0);  // reset
        vecs[1]  = mk(0, 0, 1, 3'd0, 3'd3, 0);
        vecs[2]  = mk(0, 0, 1, 3'd0, 3'd2, 0);
        vecs[3]  = mk(0, 0, 1, 3'd0, 3'd1, 0);
        vecs[4]  = mk(0, 0, 1, 3'd0, 3'd0, 0);
        vecs[5]  = mk(0, 0, 1, 3'd0, 3'd4, 1);  // wrap, borrow pulse
        vecs[6]  = mk(0, 0, 1, 3'd0, 3'd3, 0);
        vecs[7]  = mk(0, 1, 1, 3'd1, 3'd1, 0);  // load beats en
        vecs[8]  = mk(0, 1, 0, 3'd7, 3'd4, 0);  // clamp
        vecs[9]  = mk(0, 1, 0, 3'd5, 3'd4, 0);  // clamp at MODULUS
        vecs[10] = mk(0, 1, 0, 3'd2, 3'd2, 0);
        vecs[11] = mk(0, 0, 0, 3'd0, 3'd2, 0);  // hold x3
        vecs[12] = mk(0, 0, 0, 3'd0, 3'd2, 0);
        vecs[13] = mk(0, 0, 0, 3'd0, 3'd2, 0);
        vecs[14] = mk(0, 0, 1, 3'd0, 3'd1, 0);
        vecs[15] = mk(1, 1, 1, 3'd0, 3'd4, 0);  // reset beats load and en
        vecs[16] = mk(0, 0, 1, 3'd0, 3'd3, 0);
        vecs[17] = mk(0, 0, 1, 3'd0, 3'd2, 0);
        vecs[18] = mk(0, 1, 0, 3'd0, 3'd0, 0);
        vecs[19] = mk(0, 0, 1, 3'd0, 3'd4, 1);  // wrap from loaded 0
        vecs[20] = mk(0, 1, 0, 3'd4, 3'd4, 0);
        vecs[21] = mk(0, 1, 1, 3'd0, 3'd0, 0);
        vecs[22] = mk(1, 0, 0, 3'd0, 3'd4, 0);

        seq_q[0] = 2'd2; seq_q[1] = 2'd1; seq_q[2] = 2'd0; seq_q[3] = 2'd3;
        seq_q[4] = 2'd2; seq_q[5] = 2'd1; seq_q[6] = 2'd0; seq_q[7] = 2'd3;
        seq_b[0] = 0; seq_b[1] = 0; seq_b[2] = 0; seq_b[3] = 1;
        seq_b[4] = 0; seq_b[5] = 0; seq_b[6] = 0; seq_b[7] = 1;

        // 2-bit mod-4 counter: reset, then eight enabled edges.
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        check_a("a_reset", 2'd3, 1'b0, 1'b0);
        $display("a reset: q=%0d tc=%b borrow=%b", q_a, tc_a, borrow_a);
        en_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check_a($sformatf("a_count%0d", i), seq_q[i], seq_b[i], seq_q[i] == 2'd0);
            $display("a count %0d: q=%0d tc=%b borrow=%b", i, q_a, tc_a, borrow_a);
        end
        en_a = 1'b0;

        // 3-bit mod-5 counter: table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            rst_b = vecs[i].rst; load_b = vecs[i].ld; en_b = vecs[i].en; lv_b = vecs[i].lv;
            @(posedge clk); #1;
            checks++;
            if (q_b !== vecs[i].exp_q || borrow_b !== vecs[i].exp_borrow ||
                tc_b !== ((vecs[i].exp_q == 3'd0) && vecs[i].en)) begin
                errors++;
                $display("FAIL vec%0d: q=%0d borrow=%b tc=%b, required q=%0d borrow=%b tc=%b",
                         i, q_b, borrow_b, tc_b, vecs[i].exp_q, vecs[i].exp_borrow,
                         (vecs[i].exp_q == 3'd0) && vecs[i].en);
            end
            $display("b vec %0d: rst=%b load=%b en=%b lv=%0d -> q=%0d tc=%b borrow=%b",
                     i, vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].lv, q_b, tc_b, borrow_b);
        end

        rst_b = 1'b0; load_b = 1'b0; en_b = 1'b0;
        @(posedge clk); #6;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
